// File: rtl/ariane_pkg.sv
// Shared pipeline types: exception record, scoreboard entry and sizing.
// Imported by the scoreboard and its bench.
package ariane_pkg;

    localparam int unsigned NR_SB_ENTRIES = 8;
    localparam int unsigned TRANS_ID_BITS = 5;

    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        logic                     use_pc;
        exception                 ex;
        logic                     is_compressed;
    } scoreboard_entry;

endpackage

// File: rtl/scoreboard.sv
// In-order scoreboard: allocate from decode, issue in order, collect
// out-of-order writebacks by transaction id, present head for commit.
module scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    input  scoreboard_entry          decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     decoded_instr_ack_o,
    output scoreboard_entry          issue_instr_o,
    output logic                     issue_instr_valid_o,
    input  logic                     issue_ack_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [63:0]              wbdata_i,
    input  exception                 ex_i,
    input  logic                     wb_valid_i,
    output scoreboard_entry          commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i
);

    localparam int unsigned PTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    scoreboard_entry  mem_q [NR_ENTRIES];
    scoreboard_entry  mem_d [NR_ENTRIES];
    logic [PTR_W-1:0] commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0] issue_ptr_q, issue_ptr_d;
    logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0] pending_cnt_q, pending_cnt_d;

    logic [CNT_W-1:0] occupancy;
    logic             dec_fire;
    logic             iss_fire;
    logic             com_fire;
    logic [PTR_W-1:0] wb_idx;
    logic [PTR_W-1:0] wb_off;
    logic             wb_in_range;
    logic             wb_hit;

    // Handshake and status outputs from current state
    always_comb begin
        occupancy           = issued_cnt_q + pending_cnt_q;
        full_o              = (occupancy == CNT_W'(NR_ENTRIES));
        decoded_instr_ack_o = decoded_instr_valid_i && !full_o && !flush_i;
        issue_instr_o       = mem_q[issue_ptr_q];
        issue_instr_valid_o = (pending_cnt_q != '0);
        commit_instr_o      = mem_q[commit_ptr_q];
        commit_valid_o      = (issued_cnt_q != '0) && mem_q[commit_ptr_q].valid;
        dec_fire            = decoded_instr_ack_o;
        iss_fire            = issue_ack_i && issue_instr_valid_o;
        com_fire            = commit_ack_i && commit_valid_o;
        // Writebacks only land inside the issued window [head, issue_ptr)
        wb_idx              = trans_id_i[PTR_W-1:0];
        wb_off              = wb_idx - commit_ptr_q;
        wb_in_range         = ({1'b0, trans_id_i} < (TRANS_ID_BITS + 1)'(NR_ENTRIES));
        wb_hit              = wb_valid_i && wb_in_range
                              && (CNT_W'(wb_off) < issued_cnt_q);
    end

    // Next-state for entry array, pointers and counters
    always_comb begin
        mem_d         = mem_q;
        commit_ptr_d  = commit_ptr_q;
        issue_ptr_d   = issue_ptr_q;
        top_ptr_d     = top_ptr_q;
        issued_cnt_d  = issued_cnt_q;
        pending_cnt_d = pending_cnt_q;

        if (flush_i) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_d[i].valid = 1'b0;
            end
            commit_ptr_d  = '0;
            issue_ptr_d   = '0;
            top_ptr_d     = '0;
            issued_cnt_d  = '0;
            pending_cnt_d = '0;
        end else begin
            if (dec_fire) begin
                mem_d[top_ptr_q]          = decoded_instr_i;
                mem_d[top_ptr_q].trans_id = TRANS_ID_BITS'(top_ptr_q);
                mem_d[top_ptr_q].valid    = 1'b0;
                top_ptr_d                 = top_ptr_q + PTR_W'(1);
            end
            if (iss_fire) begin
                issue_ptr_d = issue_ptr_q + PTR_W'(1);
            end
            if (wb_hit) begin
                mem_d[wb_idx].result = wbdata_i;
                mem_d[wb_idx].valid  = 1'b1;
                if (ex_i.valid) begin
                    mem_d[wb_idx].ex = ex_i;
                end
            end
            if (com_fire) begin
                mem_d[commit_ptr_q].valid = 1'b0;
                commit_ptr_d              = commit_ptr_q + PTR_W'(1);
            end
            pending_cnt_d = pending_cnt_q + CNT_W'(dec_fire) - CNT_W'(iss_fire);
            issued_cnt_d  = issued_cnt_q + CNT_W'(iss_fire) - CNT_W'(com_fire);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= '0;
            end
            commit_ptr_q  <= '0;
            issue_ptr_q   <= '0;
            top_ptr_q     <= '0;
            issued_cnt_q  <= '0;
            pending_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NR_ENTRIES); i++) begin
                mem_q[i] <= mem_d[i];
            end
            commit_ptr_q  <= commit_ptr_d;
            issue_ptr_q   <= issue_ptr_d;
            top_ptr_q     <= top_ptr_d;
            issued_cnt_q  <= issued_cnt_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- In-order circular buffer of scoreboard_entry records. Sits between the decode stage (upstream) and the issue/execute/commit path (downstream).
- Accepts decoded instructions, hands them out in order for issue, and collects out-of-order functional-unit writebacks by transaction id.
- Presents the oldest completed instruction for in-order commit.
- Central bookkeeping structure of the ariane_pkg pipeline.

Parameters:
- NR_ENTRIES, 8, number of scoreboard slots; power of two, 2..32 (fits 5-bit trans_id).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of all entries
- full_o  out  1  no free slot
- decoded_instr_i  in  $bits(scoreboard_entry)  new instruction from decode
- decoded_instr_valid_i  in  1  decode offers instruction
- decoded_instr_ack_o  out  1  instruction accepted this cycle
- issue_instr_o  out  $bits(scoreboard_entry)  oldest un-issued entry
- issue_instr_valid_o  out  1  issue_instr_o meaningful
- issue_ack_i  in  1  issue stage took issue_instr_o
- trans_id_i  in  5  writeback slot index
- wbdata_i  in  64  writeback result
- ex_i  in  $bits(exception)  writeback exception
- wb_valid_i  in  1  writeback strobe
- commit_instr_o  out  $bits(scoreboard_entry)  head entry
- commit_valid_o  out  1  head is issued and complete
- commit_ack_i  in  1  commit stage retires head

Behaviour:
- State: mem[NR_ENTRIES]; commit_ptr (head), issue_ptr, top_ptr (tail); issued_cnt (head..issue_ptr); pending_cnt (issue_ptr..top_ptr).
  - All pointers wrap modulo NR_ENTRIES.
  - Total occupancy = issued_cnt + pending_cnt.
- Reset (rst_ni low, asynchronous): pointers and counters 0, all mem valid bits and ex.valid 0.
  - Outputs after reset: full_o=0, decoded_instr_ack_o=0, issue_instr_valid_o=0, commit_valid_o=0.
- full_o = (occupancy == NR_ENTRIES), combinational from current registers.
- Decode:
  - decoded_instr_ack_o = decoded_instr_valid_i && !full_o && !flush_i.
  - On ack, at the clock edge: mem[top_ptr] is written with decoded_instr_i, except trans_id forced to top_ptr and valid forced to 0; ex is copied as given (decode exceptions survive).
  - Then top_ptr++ and pending_cnt++.
- Issue:
  - issue_instr_valid_o = (pending_cnt != 0); issue_instr_o = mem[issue_ptr].
  - issue_ack_i while valid: issue_ptr++, pending_cnt--, issued_cnt++.
  - issue_ack_i while not valid: ignored.
  - Zero-latency bypass is NOT provided: an entry written at edge N is issuable from cycle N+1.
- Writeback:
  - wb_valid_i updates mem[trans_id_i]: result=wbdata_i, valid=1.
  - If ex_i.valid, the entry's ex is replaced by ex_i.
  - Writeback to a slot that is not in the issued window is ignored.
  - Out-of-order arrival is allowed.
- Commit:
  - commit_valid_o = (issued_cnt != 0) && mem[commit_ptr].valid; commit_instr_o = mem[commit_ptr].
  - commit_ack_i while valid: clear mem[commit_ptr].valid, commit_ptr++, issued_cnt--.
  - commit_ack_i while not valid: ignored.
- Simultaneous events in one cycle:
  - Decode, issue, writeback and commit may all occur together; counters apply the net change.
  - When full, decode is refused even if commit retires in the same cycle (ack uses the pre-edge count).
  - Writeback to the head in the same cycle as a commit cannot collide, because commit requires valid already set.
  - Issue and commit of the same entry in one cycle cannot happen: commit requires issued_cnt != 0 before the edge.
- flush_i:
  - Priority over all other updates. Next cycle: pointers and counters 0, all valid bits cleared.
  - decoded_instr_ack_o is forced low in the flush cycle.
  - Writebacks arriving in or after the flush cycle for killed ids are ignored.
- Reset mid-operation: asynchronous clear as above; no partial state survives.

Decomposition:
- ariane_pkg: add NR_SB_ENTRIES (=8) and TRANS_ID_BITS (=5).
- trans_id width in scoreboard_entry derives from TRANS_ID_BITS.
- Existing scoreboard_entry and exception typedefs are reused unchanged.
- No sub-module: the pointer/counter logic and entry array are one flat module.

Test Plan:
- Reset then idle -> full_o=0, issue_instr_valid_o=0, commit_valid_o=0.
- Decode 3 entries (rd=1,2,3) -> trans_id 0,1,2 assigned. issue_ack three times -> issue_instr_valid_o=0. Write back ids 2,0,1 with 0xA,0xB,0xC -> commit order id0(0xB), id1(0xC), id2(0xA); commit_valid_o for id0 rises only after id0's writeback.
- Fill 8 entries -> full_o=1, ninth decode not acked. Commit 1 plus decode the same cycle -> decode refused, accepted next cycle with trans_id 0 (wrap).
- Writeback with ex_i.valid=1, cause=2 to id 1 -> commit_instr_o.ex.cause=2 at that head. Writeback to un-issued id 5 -> ignored.
- flush_i with 5 entries outstanding -> next cycle all counters 0, commit_valid_o=0. Late writeback to id 3 -> no effect.
- Assert rst_ni low mid-stream with 4 entries outstanding -> outputs clear immediately (asynchronous). First post-reset decode gets trans_id 0.
